// File: rtl/nttn_seq_pkg.sv
// Shared op-codes, sequencer state encoding and derived-size helpers for nttn_sequencer.
// Pure declarations: no latency, no backpressure.
// Sizes are computed from RING_DEPTH/PE_DEPTH so the top stays parameter-driven.
package nttn_seq_pkg;

    localparam logic [2:0] OP_LOAD_TW   = 3'd0;
    localparam logic [2:0] OP_LOAD_DATA = 3'd1;
    localparam logic [2:0] OP_RUN_NTT   = 3'd2;
    localparam logic [2:0] OP_RUN_INTT  = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PULSE     = 3'd1,
        ST_STREAM    = 3'd2,
        ST_GAP       = 3'd3,
        ST_START     = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_DRAIN     = 3'd6
    } seq_state_e;

    // Forward twiddles, inverse twiddles, then the two scalar parameters.
    function automatic int tw_words(input int ring_depth, input int pe_depth);
        return 2 * ((((1 << (ring_depth - pe_depth)) - 1) + pe_depth) << pe_depth) + 2;
    endfunction

    function automatic int out_beats(input int ring_depth, input int pe_depth);
        return (1 << ring_depth) >> (pe_depth + 1);
    endfunction

endpackage

// File: rtl/nttn_sequencer.sv
// Command sequencer for the NTTN core: loads twiddles/data, starts NTT/INTT, drains results.
// Latency: accepted word on din one cycle later; result beats one cycle after bram_out.
// Backpressure: s_ready only in PULSE/STREAM, cmd_ready only in IDLE; m_* has none.
module nttn_sequencer
    import nttn_seq_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int RING_DEPTH = 10,
    parameter int PE_DEPTH   = 3,
    parameter int GAP        = 5,
    parameter int TIMEOUT    = 65535
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [2:0]                            cmd_op,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [DATA_W-1:0]                     s_data,
    output logic                                  load_w,
    output logic                                  load_data,
    output logic                                  start,
    output logic                                  start_intt,
    output logic [DATA_W-1:0]                     din,
    input  logic                                  done,
    input  logic [2*(1<<PE_DEPTH)*DATA_W-1:0]     bram_out,
    output logic                                  m_valid,
    output logic [2*(1<<PE_DEPTH)*DATA_W-1:0]     m_data,
    output logic                                  m_last,
    output logic                                  err_underrun,
    output logic                                  err_timeout,
    output logic                                  err_op,
    input  logic                                  err_clr
);

    localparam int BEAT_W = 2 * (1 << PE_DEPTH) * DATA_W;
    localparam logic [31:0] TW_LAST   = 32'(tw_words(RING_DEPTH, PE_DEPTH) - 1);
    localparam logic [31:0] DATA_LAST = 32'((1 << RING_DEPTH) - 1);
    localparam logic [31:0] BEAT_LAST = 32'(out_beats(RING_DEPTH, PE_DEPTH) - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);

    seq_state_e          state_q, state_d;
    // Word, gap, timeout and beat counting never overlap, so one counter serves all.
    logic [31:0]         cnt_q, cnt_d;
    // LOAD: 1 selects twiddle load. RUN: 1 selects INTT.
    logic                sel_q, sel_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [BEAT_W-1:0]   m_data_q, m_data_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;
    logic                err_under_q, err_to_q, err_op_q;
    logic                set_under, set_to, set_op;
    logic [31:0]         words_last;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        din_d      = din_q;
        m_data_d   = m_data_q;
        m_valid_d  = 1'b0;
        m_last_d   = 1'b0;
        set_under  = 1'b0;
        set_to     = 1'b0;
        set_op     = 1'b0;
        words_last = sel_q ? TW_LAST : DATA_LAST;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cnt_d = '0;
                    case (cmd_op)
                        OP_LOAD_TW: begin
                            sel_d   = 1'b1;
                            state_d = ST_PULSE;
                        end
                        OP_LOAD_DATA: begin
                            sel_d   = 1'b0;
                            state_d = ST_PULSE;
                        end
                        OP_RUN_NTT: begin
                            sel_d   = 1'b0;
                            state_d = ST_START;
                        end
                        OP_RUN_INTT: begin
                            sel_d   = 1'b1;
                            state_d = ST_START;
                        end
                        default: set_op = 1'b1;
                    endcase
                end
            end
            ST_PULSE, ST_STREAM: begin
                if (s_valid) begin
                    din_d = s_data;
                    if (cnt_q == words_last) begin
                        state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_STREAM;
                        cnt_d   = cnt_q + 32'd1;
                    end
                end else begin
                    // The core's load timing cannot stall, so a starved stream is abandoned.
                    set_under = 1'b1;
                    din_d     = '0;
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                end
            end
            ST_GAP: begin
                din_d = '0;
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (done) begin
                    state_d   = ST_DRAIN;
                    cnt_d     = '0;
                    m_valid_d = 1'b1;
                    m_data_d  = bram_out;
                    m_last_d  = (BEAT_LAST == 32'd0);
                end else if (cnt_q == TO_LAST) begin
                    set_to  = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_DRAIN: begin
                // cnt_q is the index of the beat currently presented on m_*.
                if (cnt_q == BEAT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    m_valid_d = 1'b1;
                    m_data_d  = bram_out;
                    m_last_d  = ((cnt_q + 32'd1) == BEAT_LAST);
                    cnt_d     = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            din_q       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            err_under_q <= 1'b0;
            err_to_q    <= 1'b0;
            err_op_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            din_q       <= din_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            err_under_q <= err_clr ? 1'b0 : (err_under_q | set_under);
            err_to_q    <= err_clr ? 1'b0 : (err_to_q | set_to);
            err_op_q    <= err_clr ? 1'b0 : (err_op_q | set_op);
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign s_ready      = (state_q == ST_PULSE) || (state_q == ST_STREAM);
    assign load_w       = (state_q == ST_PULSE) && sel_q;
    assign load_data    = (state_q == ST_PULSE) && !sel_q;
    assign start        = (state_q == ST_START) && !sel_q;
    assign start_intt   = (state_q == ST_START) && sel_q;
    assign din          = din_q;
    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign m_last       = m_last_q;
    assign err_underrun = err_under_q;
    assign err_timeout  = err_to_q;
    assign err_op       = err_op_q;

endmodule

// File: tb/tb_nttn_sequencer.sv
// Scoreboard bench for nttn_sequencer: expected din words and result beats are queued by
// the stimulus and popped by an independent monitor whenever the DUT presents them.
module tb_nttn_sequencer;
    import nttn_seq_pkg::*;

    localparam int DW   = 64;
    localparam int RD   = 10;
    localparam int PD   = 3;
    localparam int GP   = 5;
    localparam int TO   = 1000;
    localparam int BW   = 2 * (1 << PD) * DW;
    localparam int TWN  = 2082;
    localparam int NW   = 1024;
    localparam int NBT  = 64;

    logic          clk, reset;
    logic          cmd_valid, cmd_ready;
    logic [2:0]    cmd_op;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          load_w, load_data, start, start_intt;
    logic [DW-1:0] din;
    logic          done;
    logic [BW-1:0] bram_out;
    logic          m_valid, m_last;
    logic [BW-1:0] m_data;
    logic          err_underrun, err_timeout, err_op, err_clr;

    nttn_sequencer #(
        .DATA_W(DW), .RING_DEPTH(RD), .PE_DEPTH(PD), .GAP(GP), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .load_w(load_w), .load_data(load_data), .start(start), .start_intt(start_intt),
        .din(din), .done(done), .bram_out(bram_out),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .err_underrun(err_underrun), .err_timeout(err_timeout), .err_op(err_op),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] d;
        logic          last;
    } beat_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] din_q[$];
    beat_t         m_q[$];
    int            c_load_w, c_load_data, c_start, c_start_intt, c_beats;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_beat(input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            for (int i = 0; i < BW / 64; i++) begin
                if (act[i*64 +: 64] !== exp[i*64 +: 64]) begin
                    $display("FAIL m_data word %0d: got %h expected %h at %0t",
                             i, act[i*64 +: 64], exp[i*64 +: 64], $time);
                    break;
                end
            end
        end
    endtask

    function automatic logic [BW-1:0] beat_pat(input int run, input int k);
        logic [BW-1:0] p;
        for (int i = 0; i < BW / 64; i++)
            p[i*64 +: 64] = {32'(run) ^ 32'hC0DE0000, 16'(k), 16'(i)};
        return p;
    endfunction

    function automatic logic [DW-1:0] wval(input logic [2:0] op, input int k);
        if (op == OP_LOAD_TW) return 64'(k + 1);
        return {32'hDA7A0000, 32'(k * 7 + 3)};
    endfunction

    // Monitor: din is checked the cycle after each handshake, result beats whenever m_valid.
    initial begin : monitor
        bit    acc;
        beat_t b;
        forever begin
            @(negedge clk);
            #2;
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (load_w)     c_load_w++;
            if (load_data)  c_load_data++;
            if (start)      c_start++;
            if (start_intt) c_start_intt++;
            if (acc) begin
                if (din_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL din_unexpected: got %0h expected no word at %0t", din, $time);
                end else begin
                    chk("din", din, din_q.pop_front());
                end
            end
            if (m_valid) begin
                c_beats++;
                if (m_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL m_valid_unexpected: got 1 expected 0 at %0t", $time);
                end else begin
                    b = m_q.pop_front();
                    chk_beat(m_data, b.d);
                    chk("m_last", 64'(m_last), 64'(b.last));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic zero_counts();
        c_load_w = 0; c_load_data = 0; c_start = 0; c_start_intt = 0; c_beats = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    // Returns in the accepting cycle, before its clock edge.
    task automatic issue_cmd(input logic [2:0] op, input logic clr);
        bit ok = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        err_clr   = clr;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (cmd_ready) ok = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL cmd_accept: got cmd_ready 0 expected 1 within 40 cycles");
        end
    endtask

    task automatic do_load(input logic [2:0] op, input int n, input int drop);
        int k = 0;
        bit fin = 0;
        zero_counts();
        issue_cmd(op, 1'b0);
        for (int cyc = 0; cyc < n + 20 && !fin; cyc++) begin
            tick();
            if (k == drop) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = (k < n) ? wval(op, k) : 64'hDEAD_BEEF_0BAD_F00D;
            end
            #1;
            if (s_ready && s_valid) begin
                din_q.push_back(s_data);
                k++;
            end else if (!s_ready) begin
                fin = 1;
            end
        end
        s_valid = 1'b0;
        chk("load_finished", 64'(fin), 64'd1);
        if (drop < 0) begin
            chk("words_taken", 64'(k), 64'(n));
            chk("gap_cmd_ready", 64'(cmd_ready), 64'd0);
            for (int i = 1; i <= GP; i++) begin
                tick();
                #1;
                chk("gap_din", din, 64'd0);
                chk("gap_cmd_ready_i", 64'(cmd_ready), 64'(i == GP));
            end
            chk("load_w_cnt", 64'(c_load_w), 64'(op == OP_LOAD_TW));
            chk("load_data_cnt", 64'(c_load_data), 64'(op == OP_LOAD_DATA));
        end else begin
            chk("underrun_words", 64'(k), 64'(drop));
            chk("err_underrun_set", 64'(err_underrun), 64'd1);
            chk("underrun_idle", 64'(cmd_ready), 64'd1);
            chk("underrun_din", din, 64'd0);
            @(negedge clk);
            err_clr = 1'b1;
            tick();
            #1;
            chk("err_underrun_clr", 64'(err_underrun), 64'd0);
        end
    endtask

    task automatic do_run(input logic [2:0] op, input int lat, input int run_id, input int rst_beat);
        bit seen = 0;
        beat_t b;
        zero_counts();
        issue_cmd(op, 1'b0);
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            #1;
            if (start || start_intt) seen = 1;
        end
        chk("start_seen", 64'(seen), 64'd1);
        if (!seen) return;
        for (int i = 0; i < lat; i++) tick();
        done     = 1'b1;
        bram_out = beat_pat(run_id, 0);
        b.d = bram_out; b.last = 1'b0;
        m_q.push_back(b);
        for (int k = 1; k < NBT; k++) begin
            tick();
            done     = k[0];
            bram_out = beat_pat(run_id, k);
            if (k == rst_beat) begin
                reset = 1'b0;
                #1;
                chk("rst_m_valid", 64'(m_valid), 64'd0);
                chk("rst_m_last", 64'(m_last), 64'd0);
                chk("rst_pulses", 64'({load_w, load_data, start, start_intt}), 64'd0);
                chk("rst_m_data", m_data[63:0], 64'd0);
                m_q.delete();
                done = 1'b0;
                tick();
                tick();
                reset = 1'b1;
                #1;
                chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
                return;
            end
            b.d = bram_out; b.last = (k == NBT - 1);
            m_q.push_back(b);
        end
        tick();
        done = 1'b0;
        #1;
        chk("drain_last_valid", 64'(m_valid), 64'd1);
        tick();
        #1;
        chk("drain_end_valid", 64'(m_valid), 64'd0);
        chk("drain_end_ready", 64'(cmd_ready), 64'd1);
        chk("beat_count", 64'(c_beats), 64'(NBT));
        chk("beats_left", 64'(m_q.size()), 64'd0);
        chk("start_cnt", 64'(c_start), 64'(op == OP_RUN_NTT));
        chk("start_intt_cnt", 64'(c_start_intt), 64'(op == OP_RUN_INTT));
    endtask

    initial begin : stim
        bit seen = 0;
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; s_valid = 1'b0; s_data = '0;
        done = 1'b0; bram_out = '0; err_clr = 1'b0;
        zero_counts();
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_din", din, 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_errors", 64'({err_underrun, err_timeout, err_op}), 64'd0);
        chk("rst_pulses0", 64'({load_w, load_data, start, start_intt}), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        do_load(OP_LOAD_TW, TWN, -1);
        do_load(OP_LOAD_DATA, NW, -1);
        do_run(OP_RUN_NTT, 700, 1, -1);
        do_run(OP_RUN_INTT, 700, 2, -1);
        do_load(OP_LOAD_DATA, NW, 99);

        // Timeout with done held low.
        zero_counts();
        issue_cmd(OP_RUN_NTT, 1'b0);
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            #1;
            if (start) seen = 1;
        end
        chk("to_start_seen", 64'(seen), 64'd1);
        for (int i = 1; i <= TO + 1; i++) begin
            tick();
            #1;
            if (i == TO - 1) chk("to_early", 64'(err_timeout), 64'd0);
            if (i == TO + 1) begin
                chk("to_set", 64'(err_timeout), 64'd1);
                chk("to_idle", 64'(cmd_ready), 64'd1);
            end
        end
        chk("to_beats", 64'(c_beats), 64'd0);
        @(negedge clk);
        err_clr = 1'b1;
        tick();
        #1;
        chk("to_clr", 64'(err_timeout), 64'd0);

        // Illegal op, then clear racing a second illegal op.
        zero_counts();
        issue_cmd(3'd5, 1'b0);
        tick();
        #1;
        chk("op_err_set", 64'(err_op), 64'd1);
        chk("op_idle", 64'(cmd_ready), 64'd1);
        chk("op_s_ready", 64'(s_ready), 64'd0);
        tick();
        tick();
        chk("op_pulses", 64'(c_load_w + c_load_data + c_start + c_start_intt), 64'd0);
        issue_cmd(3'd7, 1'b1);
        tick();
        #1;
        chk("op_clr_priority", 64'(err_op), 64'd0);

        do_run(OP_RUN_NTT, 700, 3, 10);
        do_run(OP_RUN_NTT, 300, 4, -1);

        repeat (3) tick();
        chk("din_q_empty", 64'(din_q.size()), 64'd0);
        chk("m_q_empty", 64'(m_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nttn_sequencer.md
Name: nttn_sequencer

Overview:
- Command-driven controller that sequences the NTTN core. It performs twiddle/parameter load, polynomial load, NTT/INTT start, done wait and result drain.
- Converts a valid/ready word stream into NTTN's fixed-timing `load_w`/`load_data`/`din` protocol, and its fixed-timing output beats into a valid-qualified stream.
- Sits between the host/DMA side and the NTTN instance.

Parameters:
- DATA_W, 64, word width (equals NTTN data size).
- RING_DEPTH, 10, log2 ring size N.
- PE_DEPTH, 3, log2 PE count.
- GAP, 5, idle cycles after each load before the next command is accepted.
- TIMEOUT, 65535, max cycles from start pulse to done before error.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer idle, command accepted when both high.
- cmd_op  in  3  0=LOAD_TW, 1=LOAD_DATA, 2=RUN_NTT, 3=RUN_INTT, else illegal.
- s_valid  in  1  input word available.
- s_ready  out  1  sequencer consuming a word this cycle.
- s_data  in  DATA_W  input word.
- load_w  out  1  one-cycle pulse to NTTN.
- load_data  out  1  one-cycle pulse to NTTN.
- start  out  1  one-cycle NTT start pulse.
- start_intt  out  1  one-cycle INTT start pulse.
- din  out  DATA_W  registered word to NTTN.
- done  in  1  NTTN completion.
- bram_out  in  2*PE*DATA_W  NTTN output beat.
- m_valid  out  1  result beat valid (no backpressure).
- m_data  out  2*PE*DATA_W  registered copy of bram_out.
- m_last  out  1  final beat of a drain.
- err_underrun  out  1  sticky error.
- err_timeout  out  1  sticky error.
- err_op  out  1  sticky error.
- err_clr  in  1  clears all three error flags.

Behaviour:
- Derived constants:
  - TW_WORDS = 2*((((1<<(RING_DEPTH-PE_DEPTH))-1)+PE_DEPTH)<<PE_DEPTH)+2, i.e. twiddles, inverse twiddles, then 2 params; 2082 at defaults.
  - N = 1<<RING_DEPTH.
  - OUT_BEATS = N>>(PE_DEPTH+1); 64 at defaults.
- Reset (reset=0, async):
  - State IDLE.
  - All pulses, m_valid, m_last, s_ready, din and m_data are 0; errors 0; counters 0.
  - Reset asserted mid-operation aborts immediately; no completion is reported.
- States: IDLE, PULSE, STREAM, GAP, START, WAIT_DONE, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On accept, LOAD_TW and LOAD_DATA go to PULSE; RUN_NTT and RUN_INTT go to START.
  - Illegal op: command consumed, err_op set, remain IDLE.
- PULSE (1 cycle):
  - Asserts load_w (LOAD_TW) or load_data (LOAD_DATA).
  - s_ready=1.
  - Accepted word k appears on din the next cycle.
- STREAM:
  - s_ready=1 until the word count (TW_WORDS or N, counting the word accepted in PULSE) is reached.
  - Consecutive words land on din in consecutive cycles.
- Underrun: s_valid=0 in any cycle with s_ready=1 sets err_underrun. The sequencer then abandons the load: din<=0, goes to IDLE, and skips GAP.
- GAP: din held 0 for GAP cycles after the last word, then IDLE.
- START:
  - One cycle with start (RUN_NTT) or start_intt (RUN_INTT) high.
  - Then WAIT_DONE with the timeout counter cleared.
- WAIT_DONE:
  - First cycle done==1 moves to DRAIN.
  - Counter reaching TIMEOUT sets err_timeout and goes to IDLE.
- DRAIN:
  - m_data <= bram_out captured in each of the OUT_BEATS cycles starting the cycle after done is first seen.
  - m_valid=1 for those OUT_BEATS consecutive cycles; m_last=1 on the final one.
  - Then IDLE.
  - done toggling during DRAIN is ignored.
- Errors: err_clr has priority over a simultaneous set. cmd_ready does not depend on errors.
- din changes only in PULSE/STREAM/abort/GAP; no combinational path from s_data to din.

Decomposition:
- Package nttn_seq_pkg holds:
  - op-code localparams;
  - state encoding;
  - functions for TW_WORDS and OUT_BEATS from RING_DEPTH/PE_DEPTH.
- Single module; no sub-module (word counter and timeout counter are one shared counter, since they are never active together).

Test Plan:
- Twiddle load: LOAD_TW with continuous 2082-word stream (values 1..2082) -> load_w high exactly 1 cycle; din=1..2082 on the 2082 following cycles; din=0 for 5 cycles; cmd_ready reasserts 5 cycles after the last word.
- Data load: LOAD_DATA with 1024 words -> load_data single pulse; din order matches the stream; s_ready low after word 1024.
- RUN_NTT with model raising done 700 cycles after start -> start 1 cycle, start_intt 0; 64 m_valid beats beginning the cycle after done; m_data equals model bram_out per beat; m_last only on beat 64. Repeat with RUN_INTT -> only start_intt pulses.
- Underrun: drop s_valid at word 100 of LOAD_DATA -> err_underrun=1 that cycle, state IDLE next cycle, din=0; err_clr clears it.
- Timeout (TIMEOUT=1000) with done held 0 -> err_timeout set 1000 cycles after the start pulse, no m_valid; cmd_op=5 -> err_op=1, command consumed, no pulses.
- Reset deasserted→asserted (reset=0) at beat 10 of DRAIN -> m_valid, m_last and all pulses 0 immediately; after release, cmd_ready=1 and a new RUN_NTT completes normally.
